// File: rtl/vending_pkg.sv
// Shared vending-machine definitions: coin indices, coin values and the
// change-dispense state encoding.
package vending_pkg;

  localparam logic [1:0] COIN50   = 2'd0;
  localparam logic [1:0] COIN100  = 2'd1;
  localparam logic [1:0] COIN500  = 2'd2;
  localparam logic [1:0] COIN1000 = 2'd3;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SELECT   = 3'd1,
    ISSUE    = 3'd2,
    WAIT_ACK = 3'd3,
    DONE     = 3'd4,
    FAULT    = 3'd5
  } state_t;

  // Coin value in 50-won units.
  function automatic logic [6:0] coin_value(input logic [1:0] c);
    case (c)
      COIN100:  return 7'd2;
      COIN500:  return 7'd10;
      COIN1000: return 7'd20;
      default:  return 7'd1;
    endcase
  endfunction

endpackage

// File: rtl/coin_inventory.sv
// Four saturating per-denomination hopper inventory counters with
// one increment port (refill) and one decrement port (dispense).
module coin_inventory #(
  parameter int CNT_W      = 6,
  parameter int INIT_COUNT = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  input  logic [1:0] inc_idx,
  input  logic       dec,
  input  logic [1:0] dec_idx,
  output logic [3:0] nonzero
);

  logic [3:0][CNT_W-1:0] cnt;
  logic [3:0]            inc_hit;
  logic [3:0]            dec_hit;

  always_comb begin
    inc_hit = inc ? (4'b0001 << inc_idx) : '0;
    dec_hit = dec ? (4'b0001 << dec_idx) : '0;
    for (int unsigned i = 0; i < 4; i++) begin
      nonzero[i] = |cnt[i];
    end
  end

  // A refill and a dispense of the same coin in one cycle cancel out.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < 4; i++) begin
        cnt[i] <= CNT_W'(INIT_COUNT);
      end
    end else begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (inc_hit[i] && !dec_hit[i]) begin
          if (cnt[i] != '1) cnt[i] <= cnt[i] + 1'b1;
        end else if (dec_hit[i] && !inc_hit[i]) begin
          if (cnt[i] != '0) cnt[i] <= cnt[i] - 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/change_dispense_ctrl.sv
// Greedy coin-refund sequencer: issues one hopper request per coin, waits
// for the ack with a timeout, and falls back to smaller coins as stock runs out.
module change_dispense_ctrl
  import vending_pkg::*;
#(
  parameter int CNT_W       = 6,
  parameter int INIT_COUNT  = 10,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       Start,
  input  logic [6:0] Amount,
  input  logic       Dispensed,
  input  logic       Refill,
  input  logic [1:0] RefillCoin,
  input  logic       Clear,
  output logic       Return50,
  output logic       Return100,
  output logic       Return500,
  output logic       Return1000,
  output logic       Busy,
  output logic       Done,
  output logic       Short,
  output logic       Jam,
  output logic [6:0] Remain,
  output logic       LowChange
);

  localparam int TW = $clog2(ACK_TIMEOUT + 1);

  state_t          state;
  logic [1:0]      coin;
  logic [1:0]      pick;
  logic            found;
  logic [TW-1:0]   timer;
  logic [6:0]      remain_q;
  logic            short_q;
  logic            jam_q;
  logic [3:0]      nonzero;
  logic            ack;

  assign ack = (state == WAIT_ACK) && Dispensed;

  coin_inventory #(
    .CNT_W      (CNT_W),
    .INIT_COUNT (INIT_COUNT)
  ) u_inv (
    .clk     (CLK),
    .rst     (RST),
    .inc     (Refill),
    .inc_idx (RefillCoin),
    .dec     (ack),
    .dec_idx (coin),
    .nonzero (nonzero)
  );

  // Ascending scan; the last hit is the largest usable coin.
  always_comb begin
    found = 1'b0;
    pick  = COIN50;
    for (int unsigned i = 0; i < 4; i++) begin
      if (nonzero[i] && (coin_value(2'(i)) <= remain_q)) begin
        found = 1'b1;
        pick  = 2'(i);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      coin     <= COIN50;
      timer    <= '0;
      remain_q <= '0;
      short_q  <= 1'b0;
      jam_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (Start) begin
            remain_q <= Amount;
            state    <= (Amount == '0) ? DONE : SELECT;
          end
        end
        SELECT: begin
          if (found) begin
            coin  <= pick;
            state <= ISSUE;
          end else begin
            short_q <= 1'b1;
            state   <= FAULT;
          end
        end
        ISSUE: begin
          timer <= '0;
          state <= WAIT_ACK;
        end
        WAIT_ACK: begin
          // An ack on the timeout cycle still counts as a good dispense.
          if (Dispensed) begin
            remain_q <= remain_q - coin_value(coin);
            state    <= (remain_q == coin_value(coin)) ? DONE : SELECT;
          end else if (timer == TW'(ACK_TIMEOUT - 1)) begin
            jam_q <= 1'b1;
            state <= FAULT;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        DONE: state <= IDLE;
        FAULT: begin
          if (Clear) begin
            state    <= IDLE;
            short_q  <= 1'b0;
            jam_q    <= 1'b0;
            remain_q <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign Return50   = (state == ISSUE) && (coin == COIN50);
  assign Return100  = (state == ISSUE) && (coin == COIN100);
  assign Return500  = (state == ISSUE) && (coin == COIN500);
  assign Return1000 = (state == ISSUE) && (coin == COIN1000);
  assign Busy       = (state != IDLE);
  assign Done       = (state == DONE);
  assign Short      = short_q;
  assign Jam        = jam_q;
  assign Remain     = remain_q;
  assign LowChange  = ~&nonzero;

endmodule

// File: tb/tb_change_dispense_ctrl.sv
// Self-checking bench for change_dispense_ctrl: vector table, directed corner
// sequences and randomized refunds against a greedy-change reference model.
module tb_change_dispense_ctrl;

  localparam int CNT_W = 6;
  localparam int INIT  = 10;
  localparam int TMO   = 16;
  localparam int SAT   = (1 << CNT_W) - 1;

  logic       CLK = 1'b0;
  logic       RST, Start, Dispensed, Refill, Clear;
  logic [6:0] Amount;
  logic [1:0] RefillCoin;
  logic       Return50, Return100, Return500, Return1000;
  logic       Busy, Done, Short, Jam, LowChange;
  logic [6:0] Remain;

  change_dispense_ctrl #(
    .CNT_W       (CNT_W),
    .INIT_COUNT  (INIT),
    .ACK_TIMEOUT (TMO)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .Start      (Start),
    .Amount     (Amount),
    .Dispensed  (Dispensed),
    .Refill     (Refill),
    .RefillCoin (RefillCoin),
    .Clear      (Clear),
    .Return50   (Return50),
    .Return100  (Return100),
    .Return500  (Return500),
    .Return1000 (Return1000),
    .Busy       (Busy),
    .Done       (Done),
    .Short      (Short),
    .Jam        (Jam),
    .Remain     (Remain),
    .LowChange  (LowChange)
  );

  always #5 CLK = ~CLK;

  int nerr = 0;
  int nchk = 0;

  // Reference model state: hopper stock and coin values in 50-won units.
  int inv[4];
  int vals[4] = '{1, 2, 10, 20};
  int exp_coins[$];
  int exp_short;
  int exp_rem;

  // Observations from the last refund.
  int got_n, got_first, got_last, first_cyc, end_cyc;
  int saw_done, saw_short, saw_jam;

  typedef struct {
    int amt;
    int ncoins;
    int first;
    int last;
  } vec_t;
  vec_t vecs[6];

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Greedy change: largest coin in stock not exceeding what is still owed.
  function automatic void plan(input int amt);
    int rem;
    int c;
    exp_coins.delete();
    exp_short = 0;
    rem = amt;
    while (rem > 0) begin
      c = -1;
      for (int i = 0; i < 4; i++)
        if (inv[i] > 0 && vals[i] <= rem) c = i;
      if (c < 0) begin
        exp_short = 1;
        break;
      end
      exp_coins.push_back(c);
      inv[c]--;
      rem -= vals[c];
    end
    exp_rem = rem;
  endfunction

  task automatic do_reset;
    RST = 1'b1; Start = 1'b0; Dispensed = 1'b0; Refill = 1'b0; Clear = 1'b0;
    Amount = '0; RefillCoin = '0;
    tick;
    tick;
    RST = 1'b0;
    for (int i = 0; i < 4; i++) inv[i] = INIT;
  endtask

  task automatic chk_inv;
    int low;
    low = 0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("cnt%0d", i), int'(dut.u_inv.cnt[i]), inv[i]);
      if (inv[i] == 0) low = 1;
    end
    chk("LowChange", int'(LowChange), low);
  endtask

  // dly: cycles from the Return sample to the Dispensed sample (-1 = never ack).
  // rf_coin: refill that coin on the ack cycle (-1 = none).
  task automatic refund(input int amt, input int dly, input int rf_coin, input int expect_jam);
    logic [3:0] r;
    int cd;
    int fin;
    int idx;
    plan(amt);
    Amount = 7'(amt);
    Start  = 1'b1;
    tick;
    Start  = 1'b0;
    got_n = 0; got_first = -1; got_last = -1; first_cyc = -1; end_cyc = -1;
    saw_done = 0; saw_short = 0; saw_jam = 0;
    cd = -1;
    fin = 0;
    for (int cyc = 0; cyc < 600 && fin == 0; cyc++) begin
      r = {Return1000, Return500, Return100, Return50};
      if (r != '0) begin
        chk("onehot_return", $countones(r), 1);
        idx = r[3] ? 3 : r[2] ? 2 : r[1] ? 1 : 0;
        if (got_n < exp_coins.size()) chk("coin_order", idx, exp_coins[got_n]);
        else chk("coin_extra", got_n, exp_coins.size());
        if (got_n == 0) begin
          first_cyc = cyc;
          got_first = idx;
        end
        got_last = idx;
        got_n++;
        cd = dly;
      end
      if (Done || Short || Jam) begin
        fin = 1;
        saw_done = int'(Done); saw_short = int'(Short); saw_jam = int'(Jam);
        end_cyc = cyc;
      end else begin
        Dispensed  = (cd == 0);
        Refill     = (cd == 0) && (rf_coin >= 0);
        RefillCoin = 2'(rf_coin);
        if (cd >= 0) cd--;
        tick;
        Dispensed = 1'b0;
        Refill    = 1'b0;
      end
    end
    if (fin == 0) begin
      chk("refund_timeout", 0, 1);
    end else begin
      chk("ncoins", got_n, exp_coins.size());
      if (expect_jam != 0) begin
        chk("jam", saw_jam, 1);
        chk("jam_remain", int'(Remain), amt);
      end else if (exp_short != 0) begin
        chk("short", saw_short, 1);
        chk("short_remain", int'(Remain), exp_rem);
      end else begin
        chk("done", saw_done, 1);
        chk("done_remain", int'(Remain), 0);
      end
      if (saw_done != 0) begin
        tick;
      end else begin
        Clear = 1'b1;
        tick;
        Clear = 1'b0;
        chk("clear_busy", int'(Busy), 0);
        chk("clear_flags", int'({Short, Jam}), 0);
        chk("clear_remain", int'(Remain), 0);
      end
    end
  endtask

  initial begin
    int rounds;
    int k, c;

    vecs[0] = '{amt: 37,  ncoins: 6,  first: 3,  last: 0};
    vecs[1] = '{amt: 1,   ncoins: 1,  first: 0,  last: 0};
    vecs[2] = '{amt: 20,  ncoins: 1,  first: 3,  last: 3};
    vecs[3] = '{amt: 127, ncoins: 10, first: 3,  last: 0};
    vecs[4] = '{amt: 12,  ncoins: 2,  first: 2,  last: 1};
    vecs[5] = '{amt: 0,   ncoins: 0,  first: -1, last: -1};

    do_reset;
    chk("rst_busy", int'(Busy), 0);
    chk("rst_done", int'(Done), 0);
    chk("rst_short_jam", int'({Short, Jam}), 0);
    chk("rst_remain", int'(Remain), 0);
    chk("rst_returns", int'({Return1000, Return500, Return100, Return50}), 0);
    chk("rst_lowchange", int'(LowChange), 0);

    foreach (vecs[v]) begin
      do_reset;
      refund(vecs[v].amt, 1, -1, 0);
      chk($sformatf("vec%0d_ncoins", v), got_n, vecs[v].ncoins);
      chk($sformatf("vec%0d_first", v), got_first, vecs[v].first);
      chk($sformatf("vec%0d_last", v), got_last, vecs[v].last);
      if (vecs[v].ncoins > 0) chk($sformatf("vec%0d_latency", v), first_cyc, 1);
      else chk($sformatf("vec%0d_done_latency", v), end_cyc, 0);
    end

    // Amount 37 from full stock: 1000, 500, 100 x3, 50.
    do_reset;
    refund(37, 2, -1, 0);
    chk("t1_cnt50",   int'(dut.u_inv.cnt[0]), 9);
    chk("t1_cnt100",  int'(dut.u_inv.cnt[1]), 7);
    chk("t1_cnt500",  int'(dut.u_inv.cnt[2]), 9);
    chk("t1_cnt1000", int'(dut.u_inv.cnt[3]), 9);

    // Drain the 1000 stock, then 20 units must come out as two 500s.
    do_reset;
    for (int i = 0; i < INIT; i++) refund(20, 1, -1, 0);
    chk_inv;
    refund(20, 1, -1, 0);
    chk("t2_ncoins", got_n, 2);
    chk("t2_coin", got_first, 2);

    // Drain the 50 stock, then 1 unit cannot be paid.
    do_reset;
    for (int i = 0; i < INIT; i++) refund(1, 1, -1, 0);
    chk_inv;
    refund(1, 1, -1, 0);
    chk("t3_short", saw_short, 1);
    chk("t3_no_return", got_n, 0);

    // No ack: Jam after ACK_TIMEOUT waiting cycles following the issue cycle.
    do_reset;
    refund(2, -1, -1, 1);
    chk("t4_ncoins", got_n, 1);
    chk("t4_jam_wait", end_cyc - first_cyc - 1, TMO);

    // Ack on the very last waiting cycle beats the timeout; one later jams.
    do_reset;
    refund(2, TMO, -1, 0);
    chk("t4_late_ack_done", saw_done, 1);
    do_reset;
    refund(2, TMO + 1, -1, 1);

    // Start while busy is ignored; reset mid-refund aborts cleanly.
    do_reset;
    Amount = 7'd10; Start = 1'b1; tick; Start = 1'b0;
    tick;
    chk("t5_ret500", int'(Return500), 1);
    tick;
    Amount = 7'd5; Start = 1'b1; tick; Start = 1'b0;
    Dispensed = 1'b1; tick; Dispensed = 1'b0;
    chk("t5_done", int'(Done), 1);
    tick;
    chk("t5_idle", int'(Busy), 0);
    tick;
    chk("t5_second_start_ignored", int'(Busy), 0);
    Amount = 7'd12; Start = 1'b1; tick; Start = 1'b0;
    tick;
    tick;
    Dispensed = 1'b1; tick; Dispensed = 1'b0;
    tick;
    chk("t5_ret100", int'(Return100), 1);
    tick;
    chk("t5_wait_remain", int'(Remain), 2);
    RST = 1'b1; tick; RST = 1'b0;
    for (int i = 0; i < 4; i++) inv[i] = INIT;
    chk("t5_rst_busy", int'(Busy), 0);
    chk("t5_rst_returns", int'({Return1000, Return500, Return100, Return50}), 0);
    chk_inv;

    // Refill on the same cycle as a dispense of that coin: net zero.
    do_reset;
    refund(2, 1, 1, 0);
    inv[1]++;
    chk_inv;

    // Refill saturation.
    do_reset;
    refund(0, 1, -1, 0);
    chk("t6_done_latency", end_cyc, 0);
    chk("t6_no_return", got_n, 0);
    Refill = 1'b1; RefillCoin = 2'd1;
    for (int i = 0; i < 60; i++) tick;
    Refill = 1'b0;
    inv[1] = (inv[1] + 60 > SAT) ? SAT : inv[1] + 60;
    chk("t6_sat", int'(dut.u_inv.cnt[1]), 63);
    chk_inv;

    // Randomized refunds with idle-time refills.
    do_reset;
    rounds = 40;
    for (int n = 0; n < rounds; n++) begin
      k = $urandom_range(0, 3);
      for (int j = 0; j < k; j++) begin
        c = $urandom_range(0, 3);
        Refill = 1'b1; RefillCoin = 2'(c);
        tick;
        Refill = 1'b0;
        if (inv[c] < SAT) inv[c]++;
      end
      if ($urandom_range(0, 3) == 0) refund($urandom_range(0, 127), $urandom_range(1, 4), -1, 0);
      else refund($urandom_range(0, 40), $urandom_range(1, 4), -1, 0);
      if (n % 8 == 7) chk_inv;
    end
    chk_inv;

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got 0 expected 1");
    $fatal(1, "simulation time limit");
  end

endmodule
